ram4k_copy_engine: RTL and testbench
====================================

Name: ram4k_copy_engine

Overview:
Bus-master sequencer that drives the in/load/address side of a RAM4K-style memory and consumes its out port. It is the initiator for the 4K-word memory. It performs block copy (read source, write destination) or block fill (write a constant) over 1 to 4096 words, with a start/busy/done handshake. It sits between the control logic and the data RAM so that bulk moves run without CPU cycles.

Parameters:
DATA_W, 16, memory word width
ADDR_W, 12, memory address width; depth = 2^ADDR_W = 4096
LEN_W, 13, length/counter width (ADDR_W+1), allowing length = 4096

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill; latched on accepted start
src_addr  input  ADDR_W  copy source base; latched on start
dst_addr  input  ADDR_W  destination base; latched on start
length  input  LEN_W  word count 0..4096; latched on start; values >4096 are clamped to 4096
fill_value  input  DATA_W  fill word; latched on start
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle completion pulse
words_done  output  LEN_W  count of words written in the current or most recent transfer
mem_in  output  DATA_W  write data to the RAM in port
mem_load  output  1  RAM write enable
mem_address  output  ADDR_W  RAM address
mem_out  input  DATA_W  RAM read data; combinational from mem_address

Behaviour:
- Memory model: read data is valid on mem_out in the same cycle the address is presented. A write commits at the rising edge while mem_load=1.
- States: IDLE, READ, WRITE, DONE.
- Reset: on any edge with reset=1, the block goes to IDLE, clears the index counter and words_done, and clears the data register.
  - Reset values: busy=0, done=0, mem_load=0, mem_address=0, mem_in=0, words_done=0.
  - mem_load is combinationally gated by ~reset, so no write commits on an edge where reset=1, including reset in the middle of a transfer.
- IDLE:
  - mem_load=0, mem_address=0, mem_in=0.
  - start=1 latches mode, bases, clamped length and fill_value, and clears index i and words_done.
  - Next state: length=0 goes to DONE. Otherwise copy goes to READ and fill goes to WRITE.
- READ (copy only):
  - mem_address = src_base+i, mod 4096. mem_load=0.
  - The data register captures mem_out at the edge. Next state is WRITE.
- WRITE:
  - mem_address = dst_base+i, mod 4096. mem_load=1.
  - mem_in = data register (copy) or fill_value latch (fill).
  - At the edge: i and words_done increment. If i+1 = length, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy=1 in READ and WRITE only.
- start is ignored in READ, WRITE and DONE. Port values may change during a transfer with no effect.
- Latency from the accepting edge to the done cycle:
  - copy: 2N cycles of READ/WRITE, then done.
  - fill: N cycles of WRITE, then done.
  - length=0: done in the cycle after the accepting edge, with no writes.
- Address wrap: src_base+i and dst_base+i wrap modulo 4096, e.g. base 0xFFE with length 4 touches 0xFFE, 0xFFF, 0x000, 0x001.
- Overlap: the copy is strictly forward and word by word.
  - If dst lies inside (src, src+N), already-written words are re-read, giving a replicating pattern.
  - This is defined behaviour, not an error.
- words_done holds its final value through DONE and IDLE until the next accepted start or reset.

Test Plan:
- Fill: mode=1, dst=0x100, length=4, fill_value=0xBEEF. Required: 4 consecutive cycles with mem_load=1 at 0x100..0x103; done pulses in cycle 5 after start; words_done=4; RAM readback at 0x100..0x103 = 0xBEEF.
- Copy: preload 0x010..0x012 = 0x1111, 0x2222, 0x3333; mode=0, src=0x010, dst=0x800, length=3. Required: READ/WRITE alternate for 6 cycles; addresses 0x010, 0x800, 0x011, 0x801, ...; RAM at 0x800..0x802 matches the source; done in cycle 7.
- Wrap and overlap: fill 0xFFE, length=4, value=0x00AA must write 0xFFE, 0xFFF, 0x000, 0x001. Then copy src=0x000, dst=0x001, length=3 with 0x000=0x5A5A must leave 0x001..0x003 = 0x5A5A.
- Zero length and ignored start: length=0 gives done one cycle after start with mem_load never high. start pulsed while busy during a 4-word fill must not restart or extend the fill (words_done=4).
- Reset mid-transfer: assert reset during the 2nd WRITE of a 4-word fill. Required: no write at that edge; next cycle busy=0, mem_load=0, words_done=0; only the first word modified; no done pulse.
- Maximum length: fill length=4096 (and length=5000, which is clamped). Required: exactly 4096 writes covering every address from dst_base with wrap; done in cycle 4097; words_done=4096.

Source files
------------

// File: rtl/ram4k_copy_engine.sv
// Bus-master sequencer for a 4K-word RAM: forward block copy (read then write per word)
// or constant block fill, with start/busy/done handshake.
module ram4k_copy_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state_reg, state_next;
  logic               mode_reg;
  logic [ADDR_W-1:0]  src_reg, dst_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [DATA_W-1:0]  fill_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [LEN_W-1:0]   idx_reg;
  logic [LEN_W-1:0]   words_done_reg;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   idx_inc;
  logic               load_raw;

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign idx_inc     = idx_reg + LEN_W'(1);
  assign words_done  = words_done_reg;
  // Gate with reset so an edge that resets the engine never commits a write.
  assign mem_load    = load_raw & ~reset;

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    done        = 1'b0;
    load_raw    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) state_next = DONE;
          else if (mode)         state_next = WRITE;
          else                   state_next = READ;
        end
      end
      READ: begin
        busy        = 1'b1;
        mem_address = src_reg + idx_reg[ADDR_W-1:0];
        state_next  = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        load_raw    = 1'b1;
        mem_address = dst_reg + idx_reg[ADDR_W-1:0];
        mem_in      = mode_reg ? fill_reg : data_reg;
        if (idx_inc == len_reg) state_next = DONE;
        else if (mode_reg)      state_next = WRITE;
        else                    state_next = READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mode_reg       <= 1'b0;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      fill_reg       <= '0;
      data_reg       <= '0;
      idx_reg        <= '0;
      words_done_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg       <= mode;
            src_reg        <= src_addr;
            dst_reg        <= dst_addr;
            len_reg        <= len_clamped;
            fill_reg       <= fill_value;
            idx_reg        <= '0;
            words_done_reg <= '0;
          end
        end
        READ:  data_reg <= mem_out;
        WRITE: begin
          idx_reg        <= idx_inc;
          words_done_reg <= words_done_reg + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram4k_copy_engine.sv
// Scoreboard bench for ram4k_copy_engine: a behavioural RAM plus a reference memory that
// predicts every read address and every write (address, data) of each transfer.
module tb_ram4k_copy_engine;

  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic [11:0] src_addr, dst_addr;
  logic [12:0] length;
  logic [15:0] fill_value;
  logic        busy, done, mem_load;
  logic [12:0] words_done;
  logic [15:0] mem_in, mem_out;
  logic [11:0] mem_address;

  logic [15:0] ram     [4096];
  logic [15:0] ref_mem [4096];

  typedef struct packed {logic [11:0] a; logic [15:0] d;} wr_t;
  wr_t         wr_q[$];
  logic [11:0] rd_q[$];

  int n_checks = 0;
  int n_errors = 0;

  ram4k_copy_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_in(mem_in), .mem_load(mem_load), .mem_address(mem_address), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  assign mem_out = ram[mem_address];
  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: every write and every copy read is matched against the predictions.
  wr_t mon_e;
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (mem_load) begin
        if (wr_q.size() == 0) check_val("wr_extra", {31'd0, mem_load}, 32'd0);
        else begin
          mon_e = wr_q.pop_front();
          check_val("wr_addr", {20'd0, mem_address}, {20'd0, mon_e.a});
          check_val("wr_data", {16'd0, mem_in}, {16'd0, mon_e.d});
        end
      end else if (busy) begin
        if (rd_q.size() == 0) check_val("rd_extra", {31'd0, busy}, 32'd0);
        else check_val("rd_addr", {20'd0, mem_address}, {20'd0, rd_q.pop_front()});
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // Forward word-by-word reference model; overlap replication falls out naturally.
  task automatic plan_xfer(input logic m, input logic [11:0] s, input logic [11:0] d,
                           input int n, input logic [15:0] fv);
    logic [11:0] sa, da;
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      sa = s + 12'(i);
      da = d + 12'(i);
      if (m) v = fv;
      else begin
        rd_q.push_back(sa);
        v = ref_mem[sa];
      end
      ref_mem[da] = v;
      wr_q.push_back('{a: da, d: v});
    end
  endtask

  task automatic run_xfer(input string tag, input logic m, input logic [11:0] s,
                          input logic [11:0] d, input logic [12:0] len,
                          input logic [15:0] fv, input bit poke);
    int n, exp_lat, cyc, busy_cnt;
    bit got_done;
    n = (len > 13'd4096) ? 4096 : int'(len);
    exp_lat = (n == 0) ? 1 : ((m ? n : 2 * n) + 1);
    plan_xfer(m, s, d, n, fv);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; src_addr = 12'($urandom); dst_addr = 12'($urandom);
    length = 13'd7; fill_value = 16'($urandom);
    cyc = 0; busy_cnt = 0; got_done = 0;
    while (!got_done && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 2) start = 1'b1;
      if (poke && cyc == 3) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) got_done = 1;
    end
    check_val({tag, "_latency"}, cyc, exp_lat);
    check_val({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
    check_val({tag, "_words_done"}, {19'd0, words_done}, n);
    @(negedge clk);
    check_val({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check_val({tag, "_words_hold"}, {19'd0, words_done}, n);
    check_val({tag, "_wr_left"}, wr_q.size(), 0);
    check_val({tag, "_rd_left"}, rd_q.size(), 0);
    $display("XFER %s mode=%0d src=%03h dst=%03h len=%0d cycles=%0d words_done=%0d",
             tag, m, s, d, len, cyc, words_done);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad, done_cnt;
    logic [15:0] cp_src [3];
    cp_src[0] = 16'h1111; cp_src[1] = 16'h2222; cp_src[2] = 16'h3333;
    for (int i = 0; i < 4096; i++) begin ram[i] = 16'h0; ref_mem[i] = 16'h0; end
    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_done", {31'd0, done}, 0);
    check_val("rst_load", {31'd0, mem_load}, 0);
    check_val("rst_addr", {20'd0, mem_address}, 0);
    check_val("rst_in", {16'd0, mem_in}, 0);
    check_val("rst_words", {19'd0, words_done}, 0);

    run_xfer("fill", 1'b1, 12'h000, 12'h100, 13'd4, 16'hBEEF, 0);
    for (int i = 0; i < 4; i++) check_val("fill_rb", {16'd0, ram[12'h100 + 12'(i)]}, 32'hBEEF);

    preload(12'h010, 16'h1111); preload(12'h011, 16'h2222); preload(12'h012, 16'h3333);
    run_xfer("copy", 1'b0, 12'h010, 12'h800, 13'd3, 16'h0000, 0);
    for (int i = 0; i < 3; i++) check_val("copy_rb", {16'd0, ram[12'h800 + 12'(i)]}, {16'd0, cp_src[i]});

    run_xfer("wrap", 1'b1, 12'h000, 12'hFFE, 13'd4, 16'h00AA, 0);
    check_val("wrap_rb_fff", {16'd0, ram[12'hFFF]}, 32'h00AA);
    check_val("wrap_rb_001", {16'd0, ram[12'h001]}, 32'h00AA);

    preload(12'h000, 16'h5A5A);
    run_xfer("overlap", 1'b0, 12'h000, 12'h001, 13'd3, 16'h0000, 0);
    for (int i = 1; i <= 3; i++) check_val("overlap_rb", {16'd0, ram[12'(i)]}, 32'h5A5A);

    run_xfer("zero", 1'b1, 12'h000, 12'h300, 13'd0, 16'hDEAD, 0);
    run_xfer("ignore_start", 1'b1, 12'h000, 12'h400, 13'd4, 16'h7777, 1);

    // Reset during the second WRITE of a 4-word fill.
    ref_mem[12'h200] = 16'h4444;
    wr_q.push_back('{a: 12'h200, d: 16'h4444});
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dst_addr = 12'h200; length = 13'd4; fill_value = 16'h4444;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_busy", {31'd0, busy}, 0);
    check_val("midrst_load", {31'd0, mem_load}, 0);
    check_val("midrst_words", {19'd0, words_done}, 0);
    reset = 1'b0;
    done_cnt = 0;
    repeat (6) begin @(negedge clk); if (done) done_cnt++; end
    check_val("midrst_no_done", done_cnt, 0);
    for (int i = 0; i < 4; i++)
      check_val("midrst_rb", {16'd0, ram[12'h200 + 12'(i)]}, {16'd0, ref_mem[12'h200 + 12'(i)]});
    check_val("midrst_wr_left", wr_q.size(), 0);
    $display("XFER midrst mode=1 dst=200 len=4 words_done=%0d", words_done);

    run_xfer("max4096", 1'b1, 12'h000, 12'h123, 13'd4096, 16'hC0DE, 0);
    run_xfer("clamp5000", 1'b1, 12'h000, 12'h000, 13'd5000, 16'h1234, 0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== 16'h1234) bad++;
    check_val("clamp_all_words", bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
